pucch_alpha_seq_gen: RTL

Parametrised PUCCH cyclic-shift generator with a built-in Gold-sequence engine. One `i_start` produces the hopping cyclic shift n_cs and the alpha index for every symbol of a configured span of one slot. Supported options: normal/extended CP, start-symbol offset, and interlaced m_int. It sits ahead of the PUCCH format 0/1/DMRS sequence rotators and streams one alpha per symbol over a valid/ready handshake.

---
 rtl/pucch_alpha_seq_gen.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/pucch_alpha_seq_gen.sv
// PUCCH cyclic-shift generator: Gold-sequence engine feeding per-symbol n_cs and alpha.
// One i_start produces one (alpha, n_cs, l) tuple per symbol of the configured span.
module pucch_alpha_seq_gen #(
    parameter int STEP_BITS = 8,
    parameter int NC        = 1600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_start,
    input  logic       i_ext_cp,
    input  logic [7:0] i_nslot,
    input  logic [9:0] i_nid,
    input  logic [3:0] i_m0,
    input  logic [3:0] i_mcs,
    input  logic       i_interlace,
    input  logic [3:0] i_nirb,
    input  logic [3:0] i_start_sym,
    input  logic [3:0] i_nsym,
    input  logic       i_ready,
    output logic       o_valid,
    output logic [3:0] o_alpha,
    output logic [7:0] o_ncs,
    output logic [3:0] o_sym,
    output logic       o_busy,
    output logic       o_done,
    output logic [2:0] o_dbg_state
);

    localparam int SHIFT   = $clog2(STEP_BITS);
    localparam int GEN_CYC = 8 / STEP_BITS;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_SKIP = 3'd2,
        S_GEN  = 3'd3,
        S_OUT  = 3'd4,
        S_FIN  = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic        ext_q, inter_q;
    logic [7:0]  nslot_q;
    logic [9:0]  nid_q;
    logic [3:0]  m0_q, mcs_q, nirb_q, l0_q, nsym_q;
    logic [30:0] x1_q, x1_d, x2_q, x2_d, x1_adv, x2_adv;
    logic [15:0] cnt_q, cnt_d;
    logic [4:0]  rem_q, rem_d;
    logic [3:0]  sym_q, sym_d;
    logic [7:0]  sr_q, sr_d, sr_adv;
    logic [3:0]  alpha_q, alpha_d, osym_q, osym_d;
    logic [7:0]  ncs_q, ncs_d;

    logic [4:0]  nsymb, avail, k_cnt;
    logic [15:0] sym_base, skip_bits, skip_cyc;
    logic [8:0]  m_int, sum9;

    // Slot geometry from the latched config: skip length and emitted symbol count.
    always_comb begin
        nsymb     = ext_q ? 5'd12 : 5'd14;
        sym_base  = 16'(nsymb) * 16'(nslot_q) + 16'(l0_q);
        skip_bits = 16'(NC) + (sym_base << 3);
        skip_cyc  = skip_bits >> SHIFT;
        avail     = (5'(l0_q) < nsymb) ? (nsymb - 5'(l0_q)) : 5'd0;
        k_cnt     = (5'(nsym_q) < avail) ? 5'(nsym_q) : avail;
    end

    // STEP_BITS unrolled Gold steps; register bit k holds x(n+k), c(n) = x1[0] ^ x2[0].
    always_comb begin
        x1_adv = x1_q;
        x2_adv = x2_q;
        sr_adv = sr_q;
        for (int i = 0; i < STEP_BITS; i++) begin
            sr_adv = {x1_adv[0] ^ x2_adv[0], sr_adv[7:1]};
            x1_adv = {x1_adv[3] ^ x1_adv[0], x1_adv[30:1]};
            x2_adv = {x2_adv[3] ^ x2_adv[2] ^ x2_adv[1] ^ x2_adv[0], x2_adv[30:1]};
        end
        m_int = inter_q ? 9'(nirb_q) * 9'd5 : 9'd0;
        sum9  = 9'(m0_q) + 9'(mcs_q) + m_int + 9'(sr_adv);
    end

    // Handshake: a symbol transfers on a clock edge where o_valid && i_ready; while
    // o_valid && !i_ready the registered outputs hold. i_start overrides everything.
    always_comb begin
        state_d = state_q;
        x1_d    = x1_q;
        x2_d    = x2_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        sym_d   = sym_q;
        sr_d    = sr_q;
        alpha_d = alpha_q;
        ncs_d   = ncs_q;
        osym_d  = osym_q;
        case (state_q)
            S_LOAD: begin
                x1_d    = 31'd1;
                x2_d    = {21'd0, nid_q};
                cnt_d   = skip_cyc - 16'd1;
                rem_d   = k_cnt;
                sym_d   = l0_q;
                state_d = S_SKIP;
            end
            S_SKIP: begin
                x1_d = x1_adv;
                x2_d = x2_adv;
                if (cnt_q == 16'd0) begin
                    cnt_d   = 16'(GEN_CYC - 1);
                    state_d = (rem_q == 5'd0) ? S_FIN : S_GEN;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            S_GEN: begin
                x1_d = x1_adv;
                x2_d = x2_adv;
                sr_d = sr_adv;
                if (cnt_q == 16'd0) begin
                    ncs_d   = sr_adv;
                    alpha_d = 4'(sum9 % 9'd12);
                    osym_d  = sym_q;
                    state_d = S_OUT;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            S_OUT: begin
                if (i_ready) begin
                    rem_d   = rem_q - 5'd1;
                    sym_d   = sym_q + 4'd1;
                    cnt_d   = 16'(GEN_CYC - 1);
                    state_d = (rem_q == 5'd1) ? S_FIN : S_GEN;
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = state_q;
        endcase
        if (i_start) state_d = S_LOAD;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            x1_q    <= '0;
            x2_q    <= '0;
            cnt_q   <= '0;
            rem_q   <= '0;
            sym_q   <= '0;
            sr_q    <= '0;
            alpha_q <= '0;
            ncs_q   <= '0;
            osym_q  <= '0;
            ext_q   <= 1'b0;
            inter_q <= 1'b0;
            nslot_q <= '0;
            nid_q   <= '0;
            m0_q    <= '0;
            mcs_q   <= '0;
            nirb_q  <= '0;
            l0_q    <= '0;
            nsym_q  <= '0;
        end else begin
            state_q <= state_d;
            x1_q    <= x1_d;
            x2_q    <= x2_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            sym_q   <= sym_d;
            sr_q    <= sr_d;
            alpha_q <= alpha_d;
            ncs_q   <= ncs_d;
            osym_q  <= osym_d;
            if (i_start) begin
                ext_q   <= i_ext_cp;
                inter_q <= i_interlace;
                nslot_q <= i_nslot;
                nid_q   <= i_nid;
                m0_q    <= i_m0;
                mcs_q   <= i_mcs;
                nirb_q  <= i_nirb;
                l0_q    <= i_start_sym;
                nsym_q  <= i_nsym;
            end
        end
    end

    assign o_valid     = (state_q == S_OUT);
    assign o_busy      = (state_q != S_IDLE);
    assign o_done      = (state_q == S_FIN);
    assign o_alpha     = alpha_q;
    assign o_ncs       = ncs_q;
    assign o_sym       = osym_q;
    assign o_dbg_state = state_q;

endmodule
